// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing source (hcount/vcount, syncs, blanks, frame start)
//
// Purpose: head of the pixel pipeline. Walks the raster one pixel per enabled
// clock and produces the timing every downstream stage forwards unchanged.
// Default timing is SVGA 800x600@60 Hz at a 40 MHz pixel clock.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active-high
//   en           in   advance enable; 0 holds every output (frame_start drops to 0)
//   hcount_out   out  [10:0] horizontal position, 0..H_TOTAL-1
//   vcount_out   out  [10:0] vertical position, 0..V_TOTAL-1
//   hsync_out    out  horizontal sync, active level HS_POL
//   vsync_out    out  vertical sync, active level VS_POL
//   hblnk_out    out  1 while hcount_out >= H_ACTIVE
//   vblnk_out    out  1 while vcount_out >= V_ACTIVE
//   frame_start  out  one-cycle pulse when the counters wrap to (0,0)

module vga_timing_gen #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 40,
   parameter int   H_SYNC   = 128,
   parameter int   H_BP     = 88,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 4,
   parameter int   V_BP     = 23,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counters are 11 bits wide; anything larger cannot be represented.
   generate
      if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_timing
         $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2048");
      end
   endgenerate

   localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic        h_last;
   logic        v_last;
   logic [10:0] h_next;
   logic [10:0] v_next;
   logic        hs_act_next;
   logic        vs_act_next;

   // Flags are derived from the next counter values so that, once registered,
   // they line up with the counters they describe.
   always_comb begin
      h_last = (hcount_out == H_LAST);
      v_last = (vcount_out == V_LAST);
      h_next = h_last ? 11'd0 : hcount_out + 11'd1;
      if (h_last)
         v_next = v_last ? 11'd0 : vcount_out + 11'd1;
      else
         v_next = vcount_out;
      hs_act_next = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
      vs_act_next = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_out  <= 11'd0;
         vcount_out  <= 11'd0;
         hsync_out   <= ~HS_POL;
         vsync_out   <= ~VS_POL;
         hblnk_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         hcount_out  <= h_next;
         vcount_out  <= v_next;
         hsync_out   <= hs_act_next ? HS_POL : ~HS_POL;
         vsync_out   <= vs_act_next ? VS_POL : ~VS_POL;
         hblnk_out   <= (h_next >= H_ACT);
         vblnk_out   <= (v_next >= V_ACT);
         frame_start <= h_last && v_last;
      end else begin
         // Holding everything else, but the pulse must not stretch across stalls.
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, en_a, rst_c, en_c;

   logic [10:0] a_h, a_v, b_h, b_v, c_h, c_v;
   logic a_hs, a_vs, a_hb, a_vb, a_fs;
   logic b_hs, b_vs, b_hb, b_vb, b_fs;
   logic c_hs, c_vs, c_hb, c_vb, c_fs;

   int total = 0;
   int bad = 0;

   // default SVGA timing
   vga_timing_gen u_a (
      .clk(clk), .rst(rst_a), .en(en_a),
      .hcount_out(a_h), .vcount_out(a_v), .hsync_out(a_hs), .vsync_out(a_vs),
      .hblnk_out(a_hb), .vblnk_out(a_vb), .frame_start(a_fs)
   );

   // same timing, active-low syncs
   vga_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) u_b (
      .clk(clk), .rst(rst_a), .en(en_a),
      .hcount_out(b_h), .vcount_out(b_v), .hsync_out(b_hs), .vsync_out(b_vs),
      .hblnk_out(b_hb), .vblnk_out(b_vb), .frame_start(b_fs)
   );

   // tiny timing: H 8/1/2/1 (12), V 4/1/1/1 (7)
   vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_c (
      .clk(clk), .rst(rst_c), .en(en_c),
      .hcount_out(c_h), .vcount_out(c_v), .hsync_out(c_hs), .vsync_out(c_vs),
      .hblnk_out(c_hb), .vblnk_out(c_vb), .frame_start(c_fs)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // hand model of the small instance
   int ch = 0, cv = 0;
   int c_fs_cnt = 0;

   task automatic c_step();
      logic exp_fs;
      logic adv;
      adv = en_c;
      @(negedge clk);
      exp_fs = 1'b0;
      if (adv) begin
         if (ch == 11) begin
            ch = 0;
            if (cv == 6) begin
               cv = 0;
               exp_fs = 1'b1;
            end else begin
               cv = cv + 1;
            end
         end else begin
            ch = ch + 1;
         end
      end
      if (c_fs) c_fs_cnt++;
      check("c_h", 32'(c_h), 32'(ch));
      check("c_v", 32'(c_v), 32'(cv));
      check("c_hb", 32'(c_hb), 32'(ch >= 8));
      check("c_hs", 32'(c_hs), 32'(ch == 9 || ch == 10));
      check("c_vb", 32'(c_vb), 32'(cv >= 4));
      check("c_vs", 32'(c_vs), 32'(cv == 5));
      check("c_fs", 32'(c_fs), 32'(exp_fs));
   endtask

   initial begin
      int eh, ev, hs_cnt, bls_cnt;
      rst_a = 1'b1; en_a = 1'b0; rst_c = 1'b1; en_c = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      check("rst_a_h", 32'(a_h), 0);
      check("rst_a_v", 32'(a_v), 0);
      check("rst_a_hs", 32'(a_hs), 0);
      check("rst_a_vs", 32'(a_vs), 0);
      check("rst_a_hb", 32'(a_hb), 0);
      check("rst_a_vb", 32'(a_vb), 0);
      check("rst_a_fs", 32'(a_fs), 0);
      check("rst_b_hs", 32'(b_hs), 1);
      check("rst_b_vs", 32'(b_vs), 1);
      check("rst_c_hs", 32'(c_hs), 0);

      // first enabled edge after release
      rst_a = 1'b0; en_a = 1'b1;
      @(negedge clk);
      check("first_h", 32'(a_h), 1);
      check("first_v", 32'(a_v), 0);
      check("first_fs", 32'(a_fs), 0);

      // line 0 free-run and wrap into line 1
      eh = 1; ev = 0; hs_cnt = 0; bls_cnt = 0;
      for (int i = 0; i < 1056; i++) begin
         @(negedge clk);
         eh++;
         if (eh == 1056) begin eh = 0; ev++; end
         if (a_hs) hs_cnt++;
         if (!b_hs) bls_cnt++;
         case (eh)
            799: begin check("h799_hb", 32'(a_hb), 0); check("h799_h", 32'(a_h), 799); end
            800: begin check("h800_hb", 32'(a_hb), 1); check("h800_b_hb", 32'(b_hb), 1); end
            839: begin check("h839_hs", 32'(a_hs), 0); check("h839_b_hs", 32'(b_hs), 1); end
            840: begin check("h840_hs", 32'(a_hs), 1); check("h840_b_hs", 32'(b_hs), 0); end
            967: begin check("h967_hs", 32'(a_hs), 1); check("h967_b_hs", 32'(b_hs), 0); end
            968: begin check("h968_hs", 32'(a_hs), 0); check("h968_b_hs", 32'(b_hs), 1); end
            1055: begin check("h1055_h", 32'(a_h), 1055); check("h1055_v", 32'(a_v), 0); end
            0: begin
               check("wrap_h", 32'(a_h), 0);
               check("wrap_v", 32'(a_v), 1);
               check("wrap_hb", 32'(a_hb), 0);
               check("wrap_vb", 32'(a_vb), 0);
               check("wrap_vs", 32'(a_vs), 0);
               check("wrap_fs", 32'(a_fs), 0);
               check("wrap_b_vs", 32'(b_vs), 1);
            end
            default: ;
         endcase
      end
      check("hs_width", 32'(hs_cnt), 128);
      check("b_hs_low_width", 32'(bls_cnt), 128);

      // mid-line asynchronous reset at (500,1)
      repeat (499) @(negedge clk);
      check("pre_rst_h", 32'(a_h), 500);
      check("pre_rst_v", 32'(a_v), 1);
      #2 rst_a = 1'b1;
      #1;
      check("async_h", 32'(a_h), 0);
      check("async_v", 32'(a_v), 0);
      check("async_hs", 32'(a_hs), 0);
      check("async_vs", 32'(a_vs), 0);
      check("async_b_hs", 32'(b_hs), 1);
      @(negedge clk);
      check("hold_rst_h", 32'(a_h), 0);
      rst_a = 1'b0;
      @(negedge clk);
      check("post_rst_h", 32'(a_h), 1);
      check("post_rst_v", 32'(a_v), 0);
      check("post_rst_fs", 32'(a_fs), 0);

      // small timing: one full frame of 84 cycles from reset
      rst_c = 1'b0; en_c = 1'b1;
      c_fs_cnt = 0;
      for (int i = 0; i < 84; i++) c_step();
      check("c_frame_fs_cnt", 32'(c_fs_cnt), 1);

      // walk to the last pixel, then stall around the wrap
      for (int i = 0; i < 83; i++) c_step();
      check("c_last_h", 32'(c_h), 11);
      check("c_last_v", 32'(c_v), 6);
      c_fs_cnt = 0;
      en_c = 1'b0; c_step(); c_step();
      en_c = 1'b1; c_step();
      check("c_wrap_fs", 32'(c_fs), 1);
      en_c = 1'b0; c_step();
      check("c_stall_fs", 32'(c_fs), 0);
      en_c = 1'b1; c_step();
      check("c_after_h", 32'(c_h), 1);
      check("c_toggle_fs_cnt", 32'(c_fs_cnt), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
